// File: rtl/zfp_dec_stream_arbiter_pkg.sv
// Shared types and widths for the ZFP decoder stream arbiter.
package zfp_arb_pkg;

   localparam int FRAC_W  = 52;
   localparam int EXPO_W  = 11;
   localparam int TDATA_W = 64;

   typedef struct packed {
      logic              sign;
      logic [EXPO_W-1:0] expo;
      logic [FRAC_W-1:0] frac;
   } fp_t;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

endpackage

// File: rtl/zfp_dec_stream_arbiter_if.sv
// Bundle of requester, decoder-enc, decoder-fp and result-bus signals.
// slave: the arbiter's view. master: the surrounding environment's view.
interface zfp_dec_stream_arbiter_if import zfp_arb_pkg::*; #(
   parameter int N_REQ = 4
);
   logic [N_REQ*TDATA_W-1:0] s_enc_tdata;
   logic [N_REQ-1:0]         s_enc_tlast;
   logic [N_REQ-1:0]         s_enc_valid;
   logic [N_REQ-1:0]         s_enc_ready;

   logic [TDATA_W-1:0]       dec_enc_tdata;
   logic                     dec_enc_tlast;
   logic                     dec_enc_valid;
   logic                     dec_enc_ready;

   logic [FRAC_W-1:0]        dec_fp_frac;
   logic [EXPO_W-1:0]        dec_fp_expo;
   logic                     dec_fp_sign;
   logic                     dec_fp_valid;
   logic                     dec_fp_ready;

   logic [FRAC_W-1:0]        m_fp_frac;
   logic [EXPO_W-1:0]        m_fp_expo;
   logic                     m_fp_sign;
   logic [N_REQ-1:0]         m_fp_valid;
   logic [N_REQ-1:0]         m_fp_ready;

   modport slave (
      input  s_enc_tdata, s_enc_tlast, s_enc_valid,
      output s_enc_ready,
      output dec_enc_tdata, dec_enc_tlast, dec_enc_valid,
      input  dec_enc_ready,
      input  dec_fp_frac, dec_fp_expo, dec_fp_sign, dec_fp_valid,
      output dec_fp_ready,
      output m_fp_frac, m_fp_expo, m_fp_sign, m_fp_valid,
      input  m_fp_ready
   );

   modport master (
      output s_enc_tdata, s_enc_tlast, s_enc_valid,
      input  s_enc_ready,
      input  dec_enc_tdata, dec_enc_tlast, dec_enc_valid,
      output dec_enc_ready,
      output dec_fp_frac, dec_fp_expo, dec_fp_sign, dec_fp_valid,
      input  dec_fp_ready,
      input  m_fp_frac, m_fp_expo, m_fp_sign, m_fp_valid,
      output m_fp_ready
   );
endinterface

// File: rtl/zfp_dec_stream_arbiter_tag_fifo.sv
// Tag FIFO recording which requester owns each frame in flight.
// Push is ignored when full and pop is ignored when empty.
module zfp_arb_tag_fifo #(
   parameter int W     = 2,
   parameter int DEPTH = 4
)(
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic         o_full,
   output logic         o_empty,
   output logic [W-1:0] o_head
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr;
   logic [PTR_W-1:0] r_rd;
   logic [PTR_W:0]   r_cnt;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_cnt == (PTR_W+1)'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign o_head  = r_mem[r_rd];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   // storage write; contents are only meaningful between push and pop
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr] <= i_data;
   end

   // pointer and occupancy update, wrapping at DEPTH
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= (r_wr == PTR_W'(DEPTH-1)) ? '0 : r_wr + 1'b1;
         if (w_pop)  r_rd <= (r_rd == PTR_W'(DEPTH-1)) ? '0 : r_rd + 1'b1;
         if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
         else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
      end
   end
endmodule

// File: rtl/zfp_dec_stream_arbiter.sv
// Round-robin sharing of one ZFP decoder between N_REQ stream requesters.
// Optional build macro: ZFP_ARB_PERF_EN adds perf_frames / perf_stall counters.
//
// state | meaning
// IDLE  | bubble cycle: pick next requester, push its tag
// GRANT | granted requester passes straight through to the decoder until tlast
module zfp_dec_stream_arbiter import zfp_arb_pkg::*; #(
   parameter int N_REQ         = 4,
   parameter int OUT_PER_FRAME = 16,
   parameter int TAG_DEPTH     = 4
)(
   input  logic                    clk_scclang_global_0,
   input  logic                    reset_scclang_global_5,
   zfp_dec_stream_arbiter_if.slave bus
`ifdef ZFP_ARB_PERF_EN
   ,
   output logic [N_REQ*32-1:0]     perf_frames,
   output logic [31:0]             perf_stall
`endif
);
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = (OUT_PER_FRAME > 1) ? $clog2(OUT_PER_FRAME) : 1;

   arb_state_t       r_state;
   arb_state_t       w_state_nxt;
   logic [IDX_W-1:0] r_grant;
   logic [IDX_W-1:0] r_last_grant;
   logic [IDX_W-1:0] w_pick;
   logic [IDX_W-1:0] w_sel;
   logic [IDX_W-1:0] w_head;
   logic [CNT_W-1:0] r_cnt;
   logic [N_REQ-1:0] w_head_oh;
   logic             w_found;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic             w_frame_end;
   logic             w_out_hs;
   int               w_idx;
   fp_t              w_fp;

   // first valid requester searching upward from last_grant+1, wrapping
   always_comb begin
      w_pick  = '0;
      w_found = 1'b0;
      w_idx   = 0;
      w_sel   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         w_idx = (int'(r_last_grant) + k) % N_REQ;
         w_sel = IDX_W'(w_idx);
         if (!w_found && bus.s_enc_valid[w_sel]) begin
            w_pick  = w_sel;
            w_found = 1'b1;
         end
      end
   end

   // state register with grant bookkeeping
   always_ff @(posedge clk_scclang_global_0) begin
      if (reset_scclang_global_5) begin
         r_state      <= IDLE;
         r_grant      <= '0;
         r_last_grant <= IDX_W'(N_REQ-1);
      end else begin
         r_state <= w_state_nxt;
         if (w_push)      r_grant      <= w_pick;
         if (w_frame_end) r_last_grant <= r_grant;
      end
   end

   // next-state decision; a grant is only taken while the tag FIFO has room
   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_found && !w_full) begin
               w_push      = 1'b1;
               w_state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (w_frame_end) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // input-side outputs: combinational pass-through of the granted requester
   always_comb begin
      bus.dec_enc_tdata = '0;
      bus.dec_enc_tlast = 1'b0;
      bus.dec_enc_valid = 1'b0;
      bus.s_enc_ready   = '0;
      if (r_state == GRANT) begin
         bus.dec_enc_tdata        = bus.s_enc_tdata[r_grant*TDATA_W +: TDATA_W];
         bus.dec_enc_tlast        = bus.s_enc_tlast[r_grant];
         bus.dec_enc_valid        = bus.s_enc_valid[r_grant];
         bus.s_enc_ready[r_grant] = bus.dec_enc_ready;
      end
   end

   assign w_frame_end = bus.dec_enc_valid && bus.dec_enc_ready && bus.dec_enc_tlast;

   zfp_arb_tag_fifo #(
      .W     (IDX_W),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .i_clk   (clk_scclang_global_0),
      .i_rst   (reset_scclang_global_5),
      .i_push  (w_push),
      .i_data  (w_pick),
      .i_pop   (w_pop),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

   assign w_head_oh = N_REQ'(1) << w_head;

   // output steering toward the FIFO head owner; results with no owner are held
   always_comb begin
      bus.m_fp_valid   = '0;
      bus.dec_fp_ready = 1'b0;
      if (!w_empty) begin
         bus.m_fp_valid   = w_head_oh & {N_REQ{bus.dec_fp_valid}};
         bus.dec_fp_ready = bus.m_fp_ready[w_head];
      end
   end

   assign w_fp          = '{sign: bus.dec_fp_sign, expo: bus.dec_fp_expo, frac: bus.dec_fp_frac};
   assign bus.m_fp_frac = w_fp.frac;
   assign bus.m_fp_expo = w_fp.expo;
   assign bus.m_fp_sign = w_fp.sign;

   assign w_out_hs = bus.dec_fp_valid && bus.dec_fp_ready;
   assign w_pop    = w_out_hs && (r_cnt == CNT_W'(OUT_PER_FRAME-1));

   // per-frame result counter; the last result of a frame retires its tag
   always_ff @(posedge clk_scclang_global_0) begin
      if (reset_scclang_global_5) r_cnt <= '0;
      else if (w_pop)             r_cnt <= '0;
      else if (w_out_hs)          r_cnt <= r_cnt + 1'b1;
   end

`ifdef ZFP_ARB_PERF_EN
   logic [N_REQ*32-1:0] r_perf_frames;
   logic [31:0]         r_perf_stall;

   // completed-frame and decoder-backpressure counters, free-running wrap
   always_ff @(posedge clk_scclang_global_0) begin
      if (reset_scclang_global_5) begin
         r_perf_frames <= '0;
         r_perf_stall  <= '0;
      end else begin
         if (w_frame_end)
            r_perf_frames[r_grant*32 +: 32] <= r_perf_frames[r_grant*32 +: 32] + 32'd1;
         if ((r_state == GRANT) && bus.dec_enc_valid && !bus.dec_enc_ready)
            r_perf_stall <= r_perf_stall + 32'd1;
      end
   end

   assign perf_frames = r_perf_frames;
   assign perf_stall  = r_perf_stall;
`endif
endmodule
